// File: rtl/mips_cpu_hilo_unit.sv
// Iterative radix-2 multiply/divide engine and HI/LO register pair for the MIPS datapath.
// Optional divide-by-zero flag output enabled by defining HILO_DIV0_FLAG_EN.
module mips_cpu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef HILO_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MTLO  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_r;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_a_r;

  logic               is_muldiv_s;
  logic               is_signed_s;
  logic               is_div_s;
  logic               sign_a_s;
  logic               sign_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic               b_zero_s;

  // Operation decode and operand magnitudes at the launch edge.
  always_comb begin
    is_muldiv_s = 1'b0;
    is_signed_s = 1'b0;
    is_div_s    = 1'b0;
    case (op)
      OP_MULT:  begin is_muldiv_s = 1'b1; is_signed_s = 1'b1; end
      OP_MULTU: begin is_muldiv_s = 1'b1; end
      OP_DIV:   begin is_muldiv_s = 1'b1; is_signed_s = 1'b1; is_div_s = 1'b1; end
      OP_DIVU:  begin is_muldiv_s = 1'b1; is_div_s = 1'b1; end
      default:  begin is_muldiv_s = 1'b0; end
    endcase
    sign_a_s = is_signed_s & a[WIDTH-1];
    sign_b_s = is_signed_s & b[WIDTH-1];
    mag_a_s  = sign_a_s ? (~a + WIDTH'(1)) : a;
    mag_b_s  = sign_b_s ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add or restoring-subtract iteration.
  always_comb begin
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s  = trial_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (diff_s[WIDTH]) begin
        acc_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the write-back edge.
  always_comb begin
    prod_s   = neg_res_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
    quo_s    = neg_res_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
    rem_s    = neg_a_r ? (~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_r[2*WIDTH-1:WIDTH];
    b_zero_s = (opnd_r == {WIDTH{1'b0}});
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_a_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
`ifdef HILO_DIV0_FLAG_EN
      div0      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && is_muldiv_s) begin
            state_r   <= CALC;
            busy      <= 1'b1;
            cnt_r     <= CW'(WIDTH - 1);
            is_div_r  <= is_div_s;
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_a_r   <= sign_a_s;
            opnd_r    <= is_div_s ? mag_b_s : mag_a_s;
            acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          if (!is_div_r) begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end else if (b_zero_s) begin
            // Remainder path reproduces the captured dividend when the divisor is zero.
            hi <= rem_s;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
`ifdef HILO_DIV0_FLAG_EN
          div0 <= is_div_r & b_zero_s;
`endif
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Scoreboard bench for mips_cpu_hilo_unit: directed vectors, done-driven monitor.
module tb_mips_cpu_hilo_unit;

  localparam logic [2:0] MTLO = 3'b000, MULT = 3'b001, MULTU = 3'b010;
  localparam logic [2:0] DIV = 3'b011, DIVU = 3'b100, MTHI = 3'b101, MFHI = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef HILO_DIV0_FLAG_EN
  logic        div0;
`endif

  mips_cpu_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef HILO_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", {32'h0, hi}, {32'h0, e.hi});
        chk("result_lo", {32'h0, lo}, {32'h0, e.lo});
`ifdef HILO_DIV0_FLAG_EN
        chk("result_div0", {63'h0, div0}, {63'h0, e.d0});
`endif
      end
    end
  end

  task automatic drive_start(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                             input bit nowait);
    if (!nowait) @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ed0,
                        input bit nowait, input bit inject);
    exp_t e;
    int   cyc = 0;
    int   bcnt = 0;
    bit   stable = 1'b1;
    bit   seen = 1'b0;
    e.hi = ehi; e.lo = elo; e.d0 = ed0;
    sb.push_back(e);
    drive_start(o, va, vb, nowait);
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      if (inject && cyc == 5)  begin start = 1'b1; op = DIVU; a = 32'd50; b = 32'd7; end
      if (inject && cyc == 20) begin start = 1'b1; op = MTHI; a = 32'hDEAD; end
      if (inject && (cyc == 6 || cyc == 21)) start = 1'b0;
      if (busy) bcnt++;
      if (busy && (hi !== m_hi || lo !== m_lo)) stable = 1'b0;
      if (done) seen = 1'b1;
      else cyc++;
    end
    chk("done_latency", 64'(cyc), 64'd33);
    chk("busy_cycles", 64'(bcnt), 64'd33);
    chk("hilo_stable", {63'h0, stable}, 64'd1);
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] va);
    drive_start(o, va, 32'h0, 1'b0);
    if (o == MTHI) m_hi = va;
    else if (o == MTLO) m_lo = va;
    @(negedge clk);
    chk("mt_hi", {32'h0, hi}, {32'h0, m_hi});
    chk("mt_lo", {32'h0, lo}, {32'h0, m_lo});
    chk("mt_busy", {63'h0, busy}, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'h0, hi}, 64'd0);
    chk("rst_lo", {32'h0, lo}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    reset = 1'b1;

    mt(MTHI, 32'h0000A5A5);
    mt(MTLO, 32'h00005A5A);

    run_op(MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op(MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    run_op(DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op(DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 1'b0, 1'b0);
    run_op(DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op(MULT,  32'd7,        32'd6,        32'd0,        32'd42,       1'b0, 1'b0, 1'b1);

    // Back-to-back: the second start is driven in the done cycle.
    run_op(MULT,  32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 1'b0, 1'b0);
    run_op(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1'b1, 1'b0);

    drive_start(MFHI, 32'h13579BDF, 32'h0, 1'b0);
    @(negedge clk);
    chk("mfhi_ignored_hi", {32'h0, hi}, {32'h0, m_hi});
    chk("mfhi_ignored_lo", {32'h0, lo}, {32'h0, m_lo});
    chk("mfhi_ignored_busy", {63'h0, busy}, 64'd0);

    // Asynchronous reset in the middle of an iteration.
    drive_start(MULT, 32'd11, 32'd13, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_hi", {32'h0, hi}, 64'd0);
    chk("midrst_lo", {32'h0, lo}, 64'd0);
    chk("midrst_busy", {63'h0, busy}, 64'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    mt(MTLO, 32'h00001234);
    repeat (40) @(negedge clk);
    chk("pending_results", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_unit.md
# mips_cpu_hilo_unit

Sequential HI/LO producer for the MIPS datapath: a radix-2 iterative multiply/divide engine plus the HI/LO register pair written by MULT, MULTU, DIV, DIVU, MTHI and MTLO. The ALU reads `hi`/`lo` for MFHI and MFLO. The control FSM launches an operation with a one-cycle `start` and stalls HI/LO reads while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Iteration count equals `WIDTH`.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous reset, active-low.
- `start`  input  1  launch request, sampled on the rising edge.
- `op`  input  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 000 MTLO. Codes 110 and 111 (MFHI/MFLO) are ignored here.
- `a`  input  WIDTH  multiplicand or dividend; source for MTHI/MTLO.
- `b`  input  WIDTH  multiplier or divisor.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
- `hi`  output  WIDTH  HI register.
- `lo`  output  WIDTH  LO register.
- `div0`  output  1  present only with `HILO_DIV0_FLAG_EN`.

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - CALC: iterate, driven by a counter from `WIDTH-1` down to 0.
  - FIX: sign correction and HI/LO write.
- Transitions: IDLE→CALC on `start` with a mult/div `op`; CALC→FIX when the counter reaches 0; FIX→IDLE unconditionally.
- MTHI/MTLO with `start` in IDLE: write `a` into `hi`/`lo` on that edge. No state change, no `done`.
- `start` in CALC/FIX is ignored. The operation in flight is unaffected and HI/LO are not written.
- Codes 110/111, or `start` with an undefined code, leave the unit unchanged.
- Operand capture happens on the start edge. Signed ops store magnitudes plus the result signs. Later changes on `a`/`b` have no effect.
- Multiply: shift-add over magnitudes into a 2×WIDTH accumulator. In FIX, MULT negates the 64-bit product if the operand signs differ. `hi` gets the upper half, `lo` the lower half.
- Divide: restoring division over magnitudes. In FIX:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - `lo` gets the quotient, `hi` gets the remainder.
- DIV of 0x80000000 by 0xFFFFFFFF wraps: `lo`=0x80000000, `hi`=0.
- Divide by zero (DIV or DIVU, `b`=0): `hi`=`a` as captured, `lo`=all ones. Full latency still applies.
- Reset (asynchronous, any state): FSM→IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, `div0`=0. An interrupted operation is discarded.

## Timing
- Start edge at cycle 0 moves the FSM to CALC. `busy` is high from cycle 0 through cycle WIDTH (33 cycles for WIDTH=32), as a registered Moore output of CALC/FIX.
- The FIX edge (end of cycle WIDTH) writes `hi`/`lo`. In cycle WIDTH+1, `busy`=0 and `done`=1 for exactly one cycle. Results are valid from that cycle on.
- A new `start` is accepted in the same cycle `done` is high.
- MTHI/MTLO: `hi`/`lo` are visible the cycle after the start edge. Zero stall.
- `hi`/`lo` are stable (previous values) throughout CALC/FIX.

## Configuration
- `HILO_DIV0_FLAG_EN` defined:
  - `div0` is present. It is set on the FIX edge of a DIV/DIVU with captured `b`=0, and cleared on the FIX edge of any other mult/div.
  - `div0` holds between operations. MTHI/MTLO do not change it.
- Undefined: the port and its logic are absent. Divide-by-zero results are unchanged.

## Test plan
- Reset low mid-CALC of a MULT → `hi`=`lo`=0 and `busy`=0 immediately. After release, an MTLO of `a`=0x1234 gives `lo`=0x1234 the next cycle.
- MULT `a`=0xFFFFFFFD (−3), `b`=5 → `done` in cycle 33 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU `a`=100, `b`=0 → `hi`=100, `lo`=0xFFFFFFFF. With the macro defined, `div0`=1. A following DIVU 9/3 gives `lo`=3, `hi`=0, `div0`=0.
- MULT started, then `start` with DIVU and with MTHI at cycles 5 and 20 → both ignored. The final result is the MULT's, and `busy` stays high exactly 33 cycles.
- Back-to-back: new MULT `start` asserted in the `done` cycle → accepted, `busy` stays low for only that cycle, second `done` 33 cycles later.
